// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit path (serializer, TX FIFO, top).
package uart_pkg;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus history flop; emits a one-cycle pulse on each
// rising edge of an asynchronous pin-level input.
module sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serializer: strobe-driven writes from pins,
// valid/ready reads, full/empty/level flags and a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_stb,
  input  logic              clr,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LVL_MAX = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push, pop, we;

  sync_rise_det u_stb_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (wr_stb),
    .rise  (push)
  );

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == LVL_MAX);
  assign empty    = (level == '0);
  assign tx_valid = ~empty;
  assign tx_data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign overflow = overflow_q;
  assign pop      = tx_valid & tx_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      // A same-cycle pop frees the head slot, so a push at full still fits.
      if (push) begin
        if (!full || pop) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; all sampling and driving on falling edges.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_stb = 1'b0;
  logic       clr = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       full, empty, overflow;
  logic [3:0] level;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  uart_tx_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_stb   (wr_stb),
    .clr      (clr),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe high 3 cycles (commit at third rising edge), low 2 cycles.
  task automatic push_byte(input logic [7:0] b);
    wr_data = b;
    wr_stb  = 1'b1;
    repeat (3) @(negedge clk);
    wr_stb  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_byte();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);

    // Single write with latency check
    wr_data = 8'hA5;
    wr_stb  = 1'b1;
    repeat (2) @(negedge clk);
    check("wr_lat_early", tx_valid, 0);
    @(negedge clk);
    check("wr_valid", tx_valid, 1);
    check("wr_data", tx_data, 8'hA5);
    check("wr_level", level, 1);
    wr_stb = 1'b0;
    repeat (2) @(negedge clk);
    pop_byte();
    check("pop_empty", empty, 1);
    $display("single write 0xA5 done, level=%0d", level);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_level", level, 8);
    check("fill_ovf0", overflow, 0);
    push_byte(8'h09);
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 8);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), tx_data, i);
      pop_byte();
    end
    check("drain_empty", empty, 1);
    check("ovf_sticky", overflow, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_ovf", overflow, 0);
    $display("fill/overflow/drain done");

    // Wrap-around: interleaved push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h30 + 8'(i));
      sb.push_back(8'h30 + 8'(i));
      check($sformatf("wrap_lvl_%0d", i), level, sb.size());
      if (level > 3) check("wrap_lvl_max", level, 3);
      if (sb.size() >= 2) begin
        check($sformatf("wrap_data_%0d", i), tx_data, sb.pop_front());
        pop_byte();
      end
    end
    while (sb.size() > 0) begin
      check("wrap_tail", tx_data, sb.pop_front());
      pop_byte();
    end
    check("wrap_empty", empty, 1);
    check("wrap_ovf", overflow, 0);
    $display("wrap-around 20 bytes done");

    // Simultaneous push and pop at full
    for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
    check("pp_full", full, 1);
    wr_data = 8'h48;
    wr_stb  = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("pp_level", level, 8);
    check("pp_ovf", overflow, 0);
    check("pp_head", tx_data, 8'h41);
    wr_stb = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("pp_drain_%0d", i), tx_data, 8'h40 + 8'(i));
      pop_byte();
    end
    check("pp_empty", empty, 1);
    $display("simultaneous push/pop at full done");

    // Flush colliding with a push
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    check("fl_level5", level, 5);
    wr_data = 8'h55;
    wr_stb  = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("fl_level", level, 0);
    check("fl_valid", tx_valid, 0);
    check("fl_ovf", overflow, 0);
    wr_stb = 1'b0;
    repeat (2) @(negedge clk);
    push_byte(8'h66);
    check("fl_after_lvl", level, 1);
    check("fl_after_head", tx_data, 8'h66);
    pop_byte();
    $display("flush with colliding push done");

    // Long strobe: exactly one push
    wr_data = 8'h77;
    wr_stb  = 1'b1;
    repeat (50) @(negedge clk);
    check("long_lvl", level, 1);
    check("long_data", tx_data, 8'h77);
    wr_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("long_lvl_after", level, 1);
    pop_byte();
    check("long_empty", empty, 1);
    $display("long strobe done");

    // Asynchronous reset mid-operation
    push_byte(8'h99);
    check("ar_pre_lvl", level, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_level", level, 0);
    check("ar_valid", tx_valid, 0);
    check("ar_data", tx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("async reset mid-operation done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
